// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline control logic.
package arm_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // One in-flight writer as seen by the hazard detector.
    typedef struct packed {
        logic                  wb_en;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] dest;
    } trk_entry_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the ID/EXE/MEM stages and the pipeline controller.
interface pipeline_ctrl_if
    import arm_pkg::*;
#(
    parameter int REG_ADDR_W = arm_pkg::REG_ADDR_W
);

    logic                  id_valid;
    logic                  id_use_src1;
    logic                  id_use_src2;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_mem_read;
    logic                  mem_req;
    logic                  branch_taken;
    logic                  freeze_if;
    logic                  bubble_id;
    logic                  flush;
    logic                  stall_all;
    logic                  mem_ready;

    // Stage side: presents the ID/EXE/MEM status, consumes the controls.
    modport master (
        output id_valid, id_use_src1, id_use_src2, id_src1, id_src2,
               id_wb_en, id_dest, id_mem_read, mem_req, branch_taken,
        input  freeze_if, bubble_id, flush, stall_all, mem_ready
    );

    // Controller side.
    modport slave (
        input  id_valid, id_use_src1, id_use_src2, id_src1, id_src2,
               id_wb_en, id_dest, id_mem_read, mem_req, branch_taken,
        output freeze_if, bubble_id, flush, stall_all, mem_ready
    );

endinterface

// File: rtl/mem_wait_fsm.sv
// Memory-stage wait-state sequencer: stalls the whole pipeline for MEM_WAIT
// cycles per access, then signals one cycle of valid MEM data.
module mem_wait_fsm
    import arm_pkg::*;
#(
    parameter int MEM_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    output logic stall_all,
    output logic mem_ready
);

    localparam int CNT_W = $clog2(MEM_WAIT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next-state and counter update; the IDLE request cycle already counts
    // as the first stall cycle, so WAIT runs for MEM_WAIT-1 cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            // mem_req in DONE still belongs to the completing access.
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight without a ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign stall_all = ((state == ST_IDLE) && mem_req) || (state == ST_WAIT);
    assign mem_ready = (state == ST_DONE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage ARM pipeline: RAW
// hazard detection against EXE/MEM writers, memory wait states, branch flush.
module pipeline_ctrl
    import arm_pkg::*;
#(
    parameter int REG_ADDR_W = arm_pkg::REG_ADDR_W,
    parameter int MEM_WAIT   = 4,
    parameter bit FWD_EN     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    trk_entry_t            exe_trk;
    trk_entry_t            mem_trk;
    trk_entry_t            id_entry;
    logic                  hit_src1;
    logic                  hit_src2;
    logic                  hazard;
    logic                  issue;
    logic                  stall_all;
    logic                  mem_ready;
    logic                  unused_trk;

    assign src1     = bus.id_src1;
    assign src2     = bus.id_src2;
    assign id_entry = '{wb_en: bus.id_wb_en, mem_read: bus.id_mem_read, dest: bus.id_dest};

    // A load sitting in MEM never stalls anyone, so its load flag is not read.
    assign unused_trk = mem_trk.mem_read;

    function automatic logic match(input trk_entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.wb_en && (e.dest == r);
    endfunction

    // RAW detection: without forwarding any EXE/MEM writer blocks the reader;
    // with forwarding only a load still in EXE does.
    always_comb begin
        if (FWD_EN) begin
            hit_src1 = exe_trk.mem_read && match(exe_trk, src1);
            hit_src2 = exe_trk.mem_read && match(exe_trk, src2);
        end else begin
            hit_src1 = match(exe_trk, src1) || match(mem_trk, src1);
            hit_src2 = match(exe_trk, src2) || match(mem_trk, src2);
        end
        hazard = bus.id_valid &&
                 ((bus.id_use_src1 && hit_src1) || (bus.id_use_src2 && hit_src2));
    end

    // A taken branch discards the ID instruction, so it never becomes a writer.
    assign issue = bus.id_valid && !hazard && !bus.branch_taken;

    // Shadow of the EXE and MEM writers; frozen together with the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_trk <= '0;
            mem_trk <= '0;
        end else if (!stall_all) begin
            mem_trk <= exe_trk;
            exe_trk <= issue ? id_entry : '0;
        end
    end

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (bus.mem_req),
        .stall_all (stall_all),
        .mem_ready (mem_ready)
    );

    // Priority: memory stall over branch over hazard. A branch seen during a
    // stall simply waits in EXE and flushes once the stall lifts.
    assign bus.stall_all = stall_all;
    assign bus.mem_ready = mem_ready;
    assign bus.flush     = bus.branch_taken && !stall_all;
    assign bus.freeze_if = stall_all || (hazard && !bus.branch_taken);
    assign bus.bubble_id = hazard && !bus.branch_taken && !stall_all;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus hand-written corner cases.
module tb_pipeline_ctrl;

    typedef struct {
        logic       r;
        logic       iv;
        logic       u1;
        logic       u2;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       wb;
        logic [3:0] d;
        logic       mr;
        logic       mq;
        logic       br;
        logic [4:0] exp;   // {freeze_if, bubble_id, flush, stall_all, mem_ready}
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pipeline_ctrl_if bus0 ();
    pipeline_ctrl_if bus1 ();

    pipeline_ctrl #(.REG_ADDR_W(4), .MEM_WAIT(4), .FWD_EN(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipeline_ctrl #(.REG_ADDR_W(4), .MEM_WAIT(4), .FWD_EN(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic vec_t mk(input logic r, iv, u1, u2, input logic [3:0] s1, s2,
                                input logic wb, input logic [3:0] d,
                                input logic mr, mq, br, input logic [4:0] e);
        vec_t v;
        v.r = r; v.iv = iv; v.u1 = u1; v.u2 = u2; v.s1 = s1; v.s2 = s2;
        v.wb = wb; v.d = d; v.mr = mr; v.mq = mq; v.br = br; v.exp = e;
        return v;
    endfunction

    task automatic set_inputs(input vec_t v);
        rst               = v.r;
        bus0.id_valid     = v.iv;  bus1.id_valid     = v.iv;
        bus0.id_use_src1  = v.u1;  bus1.id_use_src1  = v.u1;
        bus0.id_use_src2  = v.u2;  bus1.id_use_src2  = v.u2;
        bus0.id_src1      = v.s1;  bus1.id_src1      = v.s1;
        bus0.id_src2      = v.s2;  bus1.id_src2      = v.s2;
        bus0.id_wb_en     = v.wb;  bus1.id_wb_en     = v.wb;
        bus0.id_dest      = v.d;   bus1.id_dest      = v.d;
        bus0.id_mem_read  = v.mr;  bus1.id_mem_read  = v.mr;
        bus0.mem_req      = v.mq;  bus1.mem_req      = v.mq;
        bus0.branch_taken = v.br;  bus1.branch_taken = v.br;
    endtask

    // Drive one cycle at the falling edge; sample 1 ns later, well away
    // from the rising edge that commits the state.
    task automatic step(input vec_t v, input bit sel, input string name);
        logic [4:0] got;
        @(negedge clk);
        set_inputs(v);
        #1;
        if (sel)
            got = {bus1.freeze_if, bus1.bubble_id, bus1.flush, bus1.stall_all, bus1.mem_ready};
        else
            got = {bus0.freeze_if, bus0.bubble_id, bus0.flush, bus0.stall_all, bus0.mem_ready};
        total++;
        if (got !== v.exp) begin
            bad++;
            $display("FAIL %s: fr/bub/fl/st/rdy got=%b want=%b", name, got, v.exp);
        end
    endtask

    task automatic drive_only(input vec_t v);
        @(negedge clk);
        set_inputs(v);
    endtask

    initial begin
        // Table: each row is one cycle on the FWD_EN=0 instance.
        //            r iv u1 u2 s1 s2 wb d  mr mq br  fr bub fl st rdy
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000)); // 0 idle
        tbl.push_back(mk(0,1,0,0, 0,0, 1,3, 0,0,0, 5'b00000)); // 1 writer R3
        tbl.push_back(mk(0,1,1,0, 3,0, 1,4, 0,0,0, 5'b11000)); // 2 R3 in EXE
        tbl.push_back(mk(0,1,1,0, 3,0, 1,4, 0,0,0, 5'b11000)); // 3 R3 in MEM
        tbl.push_back(mk(0,1,1,0, 3,0, 1,4, 0,0,0, 5'b00000)); // 4 reader issues
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000)); // 5 gap
        tbl.push_back(mk(0,1,0,1, 0,4, 0,0, 0,0,0, 5'b11000)); // 6 src2 vs R4 in MEM
        tbl.push_back(mk(0,1,0,1, 0,4, 0,0, 0,0,0, 5'b00000)); // 7 issues
        tbl.push_back(mk(0,1,0,0, 0,0, 1,7, 0,0,0, 5'b00000)); // 8 writer R7
        tbl.push_back(mk(0,1,0,0, 7,7, 0,0, 0,0,0, 5'b00000)); // 9 use flags off
        tbl.push_back(mk(0,0,1,0, 7,0, 0,0, 0,0,0, 5'b00000)); // 10 id_valid off
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2, 0,0,0, 5'b00000)); // 11 writer R2
        tbl.push_back(mk(0,1,1,0, 2,0, 1,9, 0,0,1, 5'b00100)); // 12 branch + hazard
        tbl.push_back(mk(0,1,1,0, 9,0, 0,0, 0,0,0, 5'b00000)); // 13 R9 never recorded
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1,0, 5'b10010)); // 14 mem request
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1,1, 5'b10010)); // 15 branch in WAIT
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1,1, 5'b10010)); // 16
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1,1, 5'b10010)); // 17
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1,1, 5'b00101)); // 18 DONE: flush + ready
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000)); // 19
        for (int k = 0; k < 2; k++) begin                       // 20..29 back-to-back
            for (int j = 0; j < 4; j++)
                tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1,0, 5'b10010));
            tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,(k == 0),0, 5'b00001));
        end
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000)); // 30
        tbl.push_back(mk(0,1,0,0, 0,0, 1,6, 0,0,0, 5'b00000)); // 31 writer R6
        for (int j = 0; j < 4; j++)                             // 32..35 hazard under stall
            tbl.push_back(mk(0,1,1,0, 6,0, 0,0, 0,1,0, 5'b10010));
        tbl.push_back(mk(0,1,1,0, 6,0, 0,0, 0,1,0, 5'b11001)); // 36 DONE, R6 still in EXE
        tbl.push_back(mk(0,1,1,0, 6,0, 0,0, 0,0,0, 5'b11000)); // 37 R6 in MEM
        tbl.push_back(mk(0,1,1,0, 6,0, 0,0, 0,0,0, 5'b00000)); // 38 issues
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000)); // 39

        // Power-up reset: first cycle unchecked, second cycle all outputs 0.
        set_inputs(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000));
        drive_only(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000));
        step(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000), 1'b0, "reset_outputs");

        foreach (tbl[i])
            step(tbl[i], 1'b0, $sformatf("row%0d", i));

        // Reset mid-traffic: writer R8 in flight, access in WAIT.
        step(mk(0,1,0,0, 0,0, 1,8, 0,0,0, 5'b00000), 1'b0, "rst_seq_writer");
        step(mk(0,0,0,0, 0,0, 0,0, 0,1,0, 5'b10010), 1'b0, "rst_seq_req");
        step(mk(0,0,0,0, 0,0, 0,0, 0,1,0, 5'b10010), 1'b0, "rst_seq_wait");
        step(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b10010), 1'b0, "rst_seq_rst_in_wait");
        step(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000), 1'b0, "rst_seq_rst_idle");
        step(mk(0,1,1,0, 8,0, 0,0, 0,0,0, 5'b00000), 1'b0, "rst_seq_trk_cleared");
        for (int j = 0; j < 5; j++)
            step(mk(0,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000), 1'b0, $sformatf("rst_seq_no_ready%0d", j));

        // Forwarding instance: only a load in EXE stalls, for one cycle.
        drive_only(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000));
        step(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 5'b00000), 1'b1, "fwd_reset");
        step(mk(0,1,0,0, 0,0, 1,5, 0,0,0, 5'b00000), 1'b1, "fwd_alu_writer");
        step(mk(0,1,1,0, 5,0, 0,0, 0,0,0, 5'b00000), 1'b1, "fwd_alu_reader");
        step(mk(0,1,0,0, 0,0, 1,5, 1,0,0, 5'b00000), 1'b1, "fwd_load");
        step(mk(0,1,1,0, 5,0, 0,0, 0,0,0, 5'b11000), 1'b1, "fwd_load_use");
        step(mk(0,1,1,0, 5,0, 0,0, 0,0,0, 5'b00000), 1'b1, "fwd_load_use_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage ARM pipeline. It generates the `freeze`, `flush` and stall controls that the IF/ID/EXE/MEM stage registers consume. It has three jobs:
- detect RAW hazards between the instruction in ID and older in-flight writers;
- sequence multi-cycle memory-stage accesses with a wait-state FSM;
- turn a taken branch from EXE into a flush.

It sits beside the stage chain in the ARM top level and replaces the constant `freeze`/`flush` registers there.

## Interface
Parameters:
- `REG_ADDR_W`, default 4: register-file address width.
- `MEM_WAIT`, default 4: total stall cycles per memory access. Must be ≥ 2.
- `FWD_EN`, default 0: 1 means a forwarding unit exists, so only load-use hazards stall.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_use_src1`, `id_use_src2` input 1 each: ID reads src1/src2.
- `id_src1`, `id_src2` input REG_ADDR_W each: ID source registers.
- `id_wb_en` input 1: ID instruction writes back.
- `id_dest` input REG_ADDR_W: ID destination register.
- `id_mem_read` input 1: ID instruction is a load.
- `mem_req` input 1: instruction now in MEM accesses memory.
- `branch_taken` input 1: EXE resolved a taken branch.
- `freeze_if` output 1: hold PC and the IF/ID register.
- `bubble_id` output 1: ID/EXE register loads a NOP.
- `flush` output 1: clear IF/ID and ID/EXE; PC loads the branch target.
- `stall_all` output 1: hold every stage register (memory wait).
- `mem_ready` output 1: one-cycle pulse; the MEM data is valid this cycle.

## Operation
Tracking pipeline:
- Two internal entries, `exe_trk` and `mem_trk`. Each is {wb_en, mem_read, dest}.
- They advance on each clock edge only when `stall_all`=0:
  - `mem_trk` ← `exe_trk`;
  - `exe_trk` ← issue ? {id_wb_en, id_mem_read, id_dest} : 0.
- issue = `id_valid` & !hazard & !`branch_taken`.
- While `stall_all`=1, both entries hold.

Hazard detection (combinational):
- match(e, r) = e.wb_en & (e.dest == r).
- With FWD_EN=0: hazard = `id_valid` & ((`id_use_src1` & (match(exe_trk, src1) | match(mem_trk, src1))) | same terms for src2).
- With FWD_EN=1: only `exe_trk` is checked, and only when `exe_trk.mem_read`=1.

Memory wait FSM, states IDLE, WAIT, DONE:
- IDLE:
  - If `mem_req`=1: load cnt = MEM_WAIT-1 and go to WAIT. `stall_all` is asserted in this same cycle (combinational).
  - Otherwise stay in IDLE.
- WAIT: `stall_all`=1.
  - If cnt==1, go to DONE.
  - Otherwise cnt decrements.
- DONE: `stall_all`=0 and `mem_ready`=1.
  - `mem_req` is ignored, because it still belongs to the completing instruction.
  - Next state is always IDLE.
- Net effect: `stall_all` is high for exactly MEM_WAIT cycles, followed by one DONE cycle.
- Back-to-back memory instructions re-enter WAIT from the IDLE cycle that follows DONE.

Output equations (priority: stall > branch > hazard):
- `stall_all` = (IDLE & `mem_req`) | WAIT.
- `flush` = `branch_taken` & !`stall_all`.
- `freeze_if` = `stall_all` | (hazard & !`branch_taken`).
- `bubble_id` = hazard & !`branch_taken` & !`stall_all`.

Boundary conditions:
- Branch during a memory stall: the branch stays in EXE. `flush` is deferred to the first cycle with `stall_all`=0.
- Branch and hazard in the same cycle: `flush`=1, `freeze_if`=0, `bubble_id`=0. The ID instruction is discarded and is not recorded in `exe_trk`.
- Matches on register index only. R15 is not special-cased; the decoder drives `id_use_*`=0 for PC-relative reads.

## Timing
- Reset: all outputs are 0, both tracking entries are 0, the FSM is in IDLE and cnt is 0.
- Reset asserted mid-WAIT aborts to IDLE at the next edge. No `mem_ready` pulse is produced.
- `freeze_if`, `bubble_id`, `flush` and `stall_all` are combinational from the inputs and current state. They must settle within the same cycle.
- `mem_ready` is registered-state decoded, with zero input-to-output paths.
- RAW stall length with FWD_EN=0:
  - 2 cycles if the producer is in EXE;
  - 1 cycle if the producer is in MEM.
- Load-use stall length with FWD_EN=1: 1 cycle.

## Structure
- Shared package `arm_pkg`:
  - `REG_ADDR_W` constant;
  - `mem_state_t` enum {IDLE, WAIT, DONE};
  - `trk_entry_t` struct {wb_en, mem_read, dest}.
- Sub-module `mem_wait_fsm`: holds the FSM and cnt; outputs `stall_all` and `mem_ready`. Hazard logic and tracking stay in `pipeline_ctrl`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles mid-traffic → all outputs 0, FSM in IDLE, tracking cleared.
- RAW, FWD_EN=0: issue a writer of R3, then a reader with src1=3 → `freeze_if`=`bubble_id`=1 for exactly 2 cycles, then the reader issues.
- FWD_EN=1: ALU writer of R5 followed by a reader of R5 → no stall. Load of R5 followed by a reader → exactly 1 bubble.
- Memory wait, MEM_WAIT=4: `mem_req` held → `stall_all`=1 for 4 cycles, then `mem_ready`=1 for 1 cycle. Two back-to-back memory instructions → 4+1+4+1 pattern.
- Branch during stall: `branch_taken`=1 in the first WAIT cycle → `flush`=0 until the DONE cycle, where `flush`=1.
- Branch plus hazard in the same cycle → `flush`=1, `freeze_if`=0, `bubble_id`=0, `exe_trk` cleared.
- Reset asserted mid-WAIT → FSM returns to IDLE with no `mem_ready` pulse.
